// File: rtl/usb_pkg.sv
// Shared definitions for the USB full-speed transmitter: line states, PIDs,
// CRC16 constants, the transmit state type and small bit-level helpers.
package usb_pkg;

  // {dp, dn}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  localparam logic [15:0] CRC16_POLY      = 16'h8005;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL  = 16'h800D;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CRC   = 3'd3,
    ST_ABORT = 3'd4,
    ST_EOP   = 3'd5,
    ST_EOP_J = 3'd6
  } tx_state_t;

  // Reflected (LSB-first) CRC16 update for one data bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[0] ^ din;
    crc16_step = {1'b0, crc[15:1]} ^ (fb ? CRC16_POLY_REFL : 16'h0000);
  endfunction

  function automatic logic [1:0] nrzi_toggle(input logic [1:0] line);
    nrzi_toggle = (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// One-bit-per-clock serial CRC16 (reflected, poly 0x8005, init 0xFFFF)
// with synchronous clear and advance enable.
module usb_crc16
  import usb_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        enable,
  input  logic        data_in,
  output logic [15:0] crc
);

  // LFSR register; clear wins over enable
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc <= CRC16_INIT;
    end else if (clear) begin
      crc <= CRC16_INIT;
    end else if (enable) begin
      crc <= crc16_step(crc, data_in);
    end else begin
      crc <= crc;
    end
  end

endmodule

// File: rtl/usb_fs_tx.sv
// USB full-speed serial transmitter: SYNC, NRZI, bit stuffing, EOP, underrun abort.
// Define USB_TX_CRC16_EN to append a CRC16 over all bytes after the PID.
module usb_fs_tx
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int SYNC_BITS    = 8,
  parameter int STUFF_LIMIT  = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       usb_dp_out,
  output logic       usb_dn_out,
  output logic       usb_oe,
  output logic       busy,
  output logic       underrun
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int SW = $clog2(STUFF_LIMIT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] STUFF_MAX = SW'(STUFF_LIMIT);
  localparam logic [7:0] SYNC_LEN  = 8'(SYNC_BITS);
  localparam logic [7:0] ABORT_LEN = 8'(STUFF_LIMIT + 1);
  localparam logic [7:0] EOP_LEN   = 8'(EOP_SE0_BITS);
  localparam logic [7:0] BYTE_LEN  = 8'd8;

  tx_state_t     state, state_d;
  logic [TW-1:0] tick_cnt, tick_cnt_d;
  logic [7:0]    bit_cnt, bit_cnt_d;
  logic [SW-1:0] stuff_cnt, stuff_cnt_d;
  logic [7:0]    shreg, shreg_d;
  logic          last, last_d;
  logic [1:0]    line, line_d;
  logic          oe, oe_d;
  logic          busy_r, busy_d;
  logic          ready, ready_d;
  logic          underrun_r, underrun_d;
  logic          emit, emit_bit, tick;

`ifdef USB_TX_CRC16_EN
  localparam logic [7:0] CRC_LEN = 8'd16;
  logic          first, first_d;
  logic [15:0]   crc_sh, crc_sh_d;
  logic          crc_clear, crc_enable;
  logic [15:0]   crc;

  usb_crc16 u_crc (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (crc_clear),
    .enable  (crc_enable),
    .data_in (emit_bit),
    .crc     (crc)
  );
`endif

  assign tick       = (tick_cnt == TICK_LAST);
  assign tx_ready   = ready;
  assign usb_dp_out = line[1];
  assign usb_dn_out = line[0];
  assign usb_oe     = oe;
  assign busy       = busy_r;
  assign underrun   = underrun_r;

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      stuff_cnt  <= '0;
      shreg      <= '0;
      last       <= 1'b0;
      line       <= LINE_J;
      oe         <= 1'b0;
      busy_r     <= 1'b0;
      ready      <= 1'b0;
      underrun_r <= 1'b0;
`ifdef USB_TX_CRC16_EN
      first      <= 1'b0;
      crc_sh     <= '0;
`endif
    end else begin
      state      <= state_d;
      tick_cnt   <= tick_cnt_d;
      bit_cnt    <= bit_cnt_d;
      stuff_cnt  <= stuff_cnt_d;
      shreg      <= shreg_d;
      last       <= last_d;
      line       <= line_d;
      oe         <= oe_d;
      busy_r     <= busy_d;
      ready      <= ready_d;
      underrun_r <= underrun_d;
`ifdef USB_TX_CRC16_EN
      first      <= first_d;
      crc_sh     <= crc_sh_d;
`endif
    end
  end

  // Next-state logic: each bit boundary selects the symbol for the following bit time
  always_comb begin
    state_d     = state;
    tick_cnt_d  = tick_cnt;
    bit_cnt_d   = bit_cnt;
    stuff_cnt_d = stuff_cnt;
    shreg_d     = shreg;
    last_d      = last;
    line_d      = line;
    oe_d        = oe;
    busy_d      = busy_r;
    underrun_d  = 1'b0;
    emit        = 1'b0;
    emit_bit    = 1'b0;
`ifdef USB_TX_CRC16_EN
    first_d     = first;
    crc_sh_d    = crc_sh;
    crc_clear   = 1'b0;
    crc_enable  = 1'b0;
`endif
    if (state == ST_IDLE) begin
      tick_cnt_d = '0;
      if (tx_valid && ready) begin
        state_d     = ST_SYNC;
        shreg_d     = tx_data;
        last_d      = tx_last;
        bit_cnt_d   = 8'd1;
        stuff_cnt_d = '0;
        oe_d        = 1'b1;
        busy_d      = 1'b1;
        line_d      = LINE_J;
        emit        = 1'b1;
        emit_bit    = (SYNC_LEN == 8'd1);
`ifdef USB_TX_CRC16_EN
        crc_clear   = 1'b1;
        first_d     = 1'b1;
`endif
      end else begin
        line_d = LINE_J;
      end
    end else begin
      tick_cnt_d = tick ? '0 : tick_cnt + TW'(1);
      if (!tick) begin
        state_d = state;
      end else if ((state == ST_SYNC || state == ST_DATA || state == ST_CRC) &&
                   stuff_cnt == STUFF_MAX) begin
        line_d      = nrzi_toggle(line);
        stuff_cnt_d = '0;
      end else begin
        case (state)
          ST_SYNC: begin
            if (bit_cnt < SYNC_LEN) begin
              emit      = 1'b1;
              emit_bit  = (bit_cnt == SYNC_LEN - 8'd1);
              bit_cnt_d = bit_cnt + 8'd1;
            end else begin
              state_d   = ST_DATA;
              emit      = 1'b1;
              emit_bit  = shreg[0];
              shreg_d   = {1'b0, shreg[7:1]};
              bit_cnt_d = 8'd1;
            end
          end
          ST_DATA: begin
            if (bit_cnt < BYTE_LEN) begin
              emit      = 1'b1;
              emit_bit  = shreg[0];
              shreg_d   = {1'b0, shreg[7:1]};
              bit_cnt_d = bit_cnt + 8'd1;
`ifdef USB_TX_CRC16_EN
              crc_enable = !first;
`endif
            end else if (last) begin
`ifdef USB_TX_CRC16_EN
              state_d   = ST_CRC;
              emit      = 1'b1;
              emit_bit  = ~crc[0];
              crc_sh_d  = {1'b0, ~crc[15:1]};
              bit_cnt_d = 8'd1;
`else
              state_d   = ST_EOP;
              line_d    = LINE_SE0;
              bit_cnt_d = 8'd1;
`endif
            end else if (tx_valid && ready) begin
              emit      = 1'b1;
              emit_bit  = tx_data[0];
              shreg_d   = {1'b0, tx_data[7:1]};
              last_d    = tx_last;
              bit_cnt_d = 8'd1;
`ifdef USB_TX_CRC16_EN
              crc_enable = 1'b1;
              first_d    = 1'b0;
`endif
            end else begin
              state_d    = ST_ABORT;
              underrun_d = 1'b1;
              bit_cnt_d  = 8'd1;
            end
          end
          ST_CRC: begin
`ifdef USB_TX_CRC16_EN
            if (bit_cnt < CRC_LEN) begin
              emit      = 1'b1;
              emit_bit  = crc_sh[0];
              crc_sh_d  = {1'b0, crc_sh[15:1]};
              bit_cnt_d = bit_cnt + 8'd1;
            end else begin
              state_d   = ST_EOP;
              line_d    = LINE_SE0;
              bit_cnt_d = 8'd1;
            end
`else
            state_d   = ST_EOP;
            line_d    = LINE_SE0;
            bit_cnt_d = 8'd1;
`endif
          end
          // Holding the level past the stuff limit marks the packet as bad
          ST_ABORT: begin
            if (bit_cnt < ABORT_LEN) begin
              bit_cnt_d = bit_cnt + 8'd1;
            end else begin
              state_d   = ST_EOP;
              line_d    = LINE_SE0;
              bit_cnt_d = 8'd1;
            end
          end
          ST_EOP: begin
            if (bit_cnt < EOP_LEN) begin
              bit_cnt_d = bit_cnt + 8'd1;
            end else begin
              state_d   = ST_EOP_J;
              line_d    = LINE_J;
              bit_cnt_d = 8'd1;
            end
          end
          ST_EOP_J: begin
            state_d   = ST_IDLE;
            line_d    = LINE_J;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
          end
          default: begin
            state_d   = ST_IDLE;
            line_d    = LINE_J;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
          end
        endcase
      end
    end
    if (emit) begin
      line_d      = emit_bit ? line_d : nrzi_toggle(line_d);
      stuff_cnt_d = emit_bit ? stuff_cnt_d + SW'(1) : '0;
    end else begin
      stuff_cnt_d = stuff_cnt_d;
    end
    // Ready is registered one cycle early so it is high exactly in the byte-end cycle
    ready_d = (state_d == ST_IDLE) ||
              (state_d == ST_DATA && !last_d && tick_cnt_d == TICK_LAST &&
               bit_cnt_d == BYTE_LEN && stuff_cnt_d != STUFF_MAX);
  end

endmodule

// File: tb/tb_usb_fs_tx.sv
// Randomised bench for usb_fs_tx: a packet-level model builds the expected
// line-symbol sequence (SYNC, stuffing, NRZI, abort hold, EOP) per bit time.
module tb_usb_fs_tx;
  import usb_pkg::*;

  localparam int CPB          = 4;
  localparam int SYNC_BITS    = 8;
  localparam int STUFF_LIMIT  = 6;
  localparam int EOP_SE0_BITS = 2;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_last  = 1'b0;
  logic       tx_ready, usb_dp_out, usb_dn_out, usb_oe, busy, underrun;

  usb_fs_tx dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .usb_dp_out (usb_dp_out),
    .usb_dn_out (usb_dn_out),
    .usb_oe     (usb_oe),
    .busy       (busy),
    .underrun   (underrun)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] pkt [0:7];
  logic [1:0] exp_q [$];
  logic [1:0] seen_q [$];
  int oe_cycles, ready_busy, ur_pulses;

  // Observe the line once per clock on the inactive edge
  always @(negedge clock) begin
    if (reset_n) begin
      if (usb_oe) begin
        seen_q.push_back({usb_dp_out, usb_dn_out});
        oe_cycles++;
      end
      if (busy && tx_ready) ready_busy++;
      if (underrun) ur_pulses++;
    end
  end

  function automatic logic [15:0] crc16_ref(input int n);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int b = 1; b < n; b++)
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ pkt[b][i];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    return c;
  endfunction

  // Packet-level model: decoded bits -> stuffed bits -> NRZI symbols -> tail
  function automatic void build_expect(input int n, input bit abort);
    bit bits [$];
    bit sb [$];
    int ones;
    logic [1:0] lvl;
    logic [15:0] c;
    exp_q.delete();
    for (int i = 0; i < SYNC_BITS - 1; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
    for (int b = 0; b < n; b++)
      for (int i = 0; i < 8; i++) bits.push_back(pkt[b][i]);
`ifdef USB_TX_CRC16_EN
    if (!abort) begin
      c = ~crc16_ref(n);
      for (int i = 0; i < 16; i++) bits.push_back(c[i]);
    end
`else
    c = 16'h0000;
`endif
    ones = 0;
    foreach (bits[i]) begin
      sb.push_back(bits[i]);
      ones = bits[i] ? ones + 1 : 0;
      if (ones == STUFF_LIMIT) begin
        sb.push_back(1'b0);
        ones = 0;
      end
    end
    lvl = LINE_J;
    foreach (sb[i]) begin
      if (!sb[i]) lvl = (lvl == LINE_J) ? LINE_K : LINE_J;
      exp_q.push_back(lvl);
    end
    if (abort) repeat (STUFF_LIMIT + 1) exp_q.push_back(lvl);
    repeat (EOP_SE0_BITS) exp_q.push_back(LINE_SE0);
    exp_q.push_back(LINE_J);
  endfunction

  task automatic run_pkt(input int n, input bit abort);
    int idx, cyc, lim;
    bit done;
    idx = 0; cyc = 0; done = 1'b0;
    seen_q.delete();
    oe_cycles = 0; ready_busy = 0; ur_pulses = 0;
    build_expect(n, abort);
    while (!done && cyc < 4000) begin
      @(negedge clock);
      cyc++;
      if (idx < n && tx_ready) begin
        tx_valid = 1'b1;
        tx_data  = pkt[idx];
        tx_last  = (idx == n - 1) && !abort;
        idx++;
      end else if (busy && !tx_ready) begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
        tx_last  = 1'($urandom_range(0, 1));
      end else begin
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        if (idx == n && !busy) done = 1'b1;
      end
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    chk("oe_cycles", 32'(oe_cycles), 32'(exp_q.size() * CPB));
    chk("ready_cycles", 32'(ready_busy), abort ? 32'(n) : 32'(n - 1));
    chk("underrun", 32'(ur_pulses), {31'd0, abort});
    lim = exp_q.size() * CPB;
    for (int i = 0; i < seen_q.size() && i < lim; i++)
      chk("line", 32'(seen_q[i]), 32'(exp_q[i / CPB]));
    chk("idle_line", {29'd0, usb_dp_out, usb_dn_out, usb_oe}, {29'd0, LINE_J, 1'b0});
  endtask

  task automatic reset_mid_data();
    int cyc;
    cyc = 0;
    @(negedge clock);
    while (!tx_ready && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    tx_last  = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    repeat (SYNC_BITS * CPB + 10) @(negedge clock);
    chk("pre_reset_oe", {31'd0, usb_oe}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_oe", {31'd0, usb_oe}, 32'd0);
    chk("rst_async_line", {30'd0, usb_dp_out, usb_dn_out}, {30'd0, LINE_J});
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_ready", {31'd0, tx_ready}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int n, gap;
    bit ab;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_oe", {31'd0, usb_oe}, 32'd0);
    chk("rst_line", {30'd0, usb_dp_out, usb_dn_out}, {30'd0, LINE_J});
    chk("rst_ready", {31'd0, tx_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_ready", {31'd0, tx_ready}, 32'd1);

    pkt[0] = 8'h00; run_pkt(1, 1'b0);
    pkt[0] = 8'hFF; run_pkt(1, 1'b0);
    pkt[0] = 8'h3C; pkt[1] = 8'hA5; run_pkt(2, 1'b0);
    pkt[0] = 8'h12; run_pkt(1, 1'b1);
    pkt[0] = PID_DATA0; run_pkt(1, 1'b0);
    pkt[0] = PID_DATA1; pkt[1] = 8'hFF; pkt[2] = 8'hFC; run_pkt(3, 1'b0);

    reset_mid_data();
    pkt[0] = 8'h3C; pkt[1] = 8'h5A; run_pkt(2, 1'b0);

    for (int t = 0; t < 40; t++) begin
      n  = $urandom_range(1, 6);
      ab = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < n; b++)
        pkt[b] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      run_pkt(n, ab);
      gap = $urandom_range(0, 5);
      repeat (gap) @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
